// File: rtl/scan_capture.sv
// scan_capture: rebuilds six per-digit words from an active-low multiplexed scan bus and checks scan order.
// Two-edge latency from bus to q; no backpressure, one select change per clock is accepted.
module scan_capture #(
  parameter int W       = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [5:0]   sel_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic [W-1:0] q3,
  output logic [W-1:0] q4,
  output logic [W-1:0] q5,
  output logic         frame_done,
  output logic         locked,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t        r_state;
  logic [5:0]    r_sel;
  logic [W-1:0]  r_din;
  logic [W-1:0]  r_q [6];
  logic [2:0]    r_prev;
  logic [2:0]    r_expect;
  logic [CW-1:0] r_cnt;
  logic          r_frame_done;
  logic          r_err;
  logic [1:0]    r_err_code;

  logic [5:0]    w_act;
  logic          w_onehot;
  logic          w_blank;
  logic          w_illegal;
  logic [2:0]    w_idx;
  logic          w_adv;
  logic          w_held;
  logic          w_order;
  logic          w_tout;
  logic [CW-1:0] w_cnt_nxt;

  assign w_act     = ~r_sel;
  assign w_onehot  = (w_act != 6'd0) && ((w_act & (w_act - 6'd1)) == 6'd0);
  assign w_blank   = (w_act == 6'd0);
  assign w_illegal = !w_onehot && !w_blank;

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (w_act[i]) w_idx = 3'(i);
    end
  end

  assign w_adv     = (r_state == LOCK) && w_onehot && (w_idx == r_expect);
  assign w_held    = (r_state == LOCK) && w_onehot && (w_idx == r_prev);
  assign w_order   = (r_state == LOCK) && w_onehot && !w_adv && !w_held;
  assign w_cnt_nxt = r_cnt + CW'(1);
  // Only an expect-path advance restarts the stall window; held and blank cycles count.
  assign w_tout    = (r_state == LOCK) && !w_adv && (w_cnt_nxt == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= HUNT;
      r_sel        <= 6'h3f;
      r_din        <= '0;
      for (int i = 0; i < 6; i++) r_q[i] <= '0;
      r_prev       <= 3'd5;
      r_expect     <= 3'd4;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      if (en) begin
        r_sel <= sel_n;
        r_din <= din;
        case (r_state)
          HUNT: begin
            r_cnt <= '0;
            if (w_onehot && (w_idx == 3'd5)) begin
              r_q[5]   <= r_din;
              r_prev   <= 3'd5;
              r_expect <= 3'd4;
              r_state  <= LOCK;
            end
          end
          LOCK: begin
            if (w_illegal || w_order) begin
              r_err      <= 1'b1;
              r_err_code <= w_illegal ? 2'b01 : 2'b10;
              r_state    <= HUNT;
              r_cnt      <= '0;
            end else if (w_adv) begin
              r_q[w_idx]   <= r_din;
              r_prev       <= w_idx;
              r_expect     <= (w_idx == 3'd0) ? 3'd5 : (w_idx - 3'd1);
              r_cnt        <= '0;
              r_frame_done <= (w_idx == 3'd0);
            end else if (w_tout) begin
              r_err      <= 1'b1;
              r_err_code <= 2'b11;
              r_state    <= HUNT;
              r_cnt      <= '0;
            end else begin
              if (w_held) r_q[w_idx] <= r_din;
              r_cnt <= w_cnt_nxt;
            end
          end
        endcase
      end
    end
  end

  assign q0         = r_q[0];
  assign q1         = r_q[1];
  assign q2         = r_q[2];
  assign q3         = r_q[3];
  assign q4         = r_q[4];
  assign q5         = r_q[5];
  assign frame_done = r_frame_done;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign locked     = (r_state == LOCK);

endmodule

// File: tb/tb_scan_capture.sv
// Bench for scan_capture: directed scan sequences push expected frame/error events into a
// scoreboard queue; a negedge monitor pops and compares whenever frame_done or err fires.
module tb_scan_capture;

  localparam int W  = 6;
  localparam int TO = 8;

  localparam int EV_NONE = 0;
  localparam int EV_FRM  = 1;
  localparam int EV_ERR  = 2;

  typedef struct packed {
    logic                 is_err;
    logic [1:0]           code;
    logic [5:0][W-1:0]    q;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  logic [5:0]   sel_n = 6'h3f;
  logic [W-1:0] din = '0;
  logic [W-1:0] q0, q1, q2, q3, q4, q5;
  logic         frame_done, locked, err;
  logic [1:0]   err_code;

  int checks = 0;
  int errors = 0;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [5:0][W-1:0] exp_q = '0;

  scan_capture #(.W(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sel_n      (sel_n),
    .din        (din),
    .q0         (q0),
    .q1         (q1),
    .q2         (q2),
    .q3         (q3),
    .q4         (q4),
    .q5         (q5),
    .frame_done (frame_done),
    .locked     (locked),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] sl(input int k);
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << k);
  endfunction

  // Drive one bus value for n cycles; wk >= 0 marks a digit the design must write with d.
  task automatic put(input logic [5:0] s, input logic [W-1:0] d, input int n,
                     input int wk, input int ev, input logic [1:0] code);
    exp_t e;
    sel_n = s;
    din   = d;
    if (wk >= 0) exp_q[wk] = d;
    if (ev != EV_NONE) begin
      e.is_err = (ev == EV_ERR);
      e.code   = code;
      e.q      = exp_q;
      sb.push_back(e);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scan from digit top down to 0, each select held 1..maxh cycles with din changing per cycle.
  task automatic scan_from(input int top, input int base, input int maxh);
    int h;
    for (int k = top; k >= 0; k--) begin
      h = (maxh > 1) ? int'($urandom_range(maxh, 1)) : 1;
      for (int j = 0; j < h; j++)
        put(sl(k), W'(base + 7 * j + k), 1, k, (k == 0 && j == 0) ? EV_FRM : EV_NONE, 2'b00);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (frame_done || err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got frame_done=%0b err=%0b code=%0b expected no event at %0t",
                 frame_done, err, err_code, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("ev_kind", 64'({err, frame_done}), 64'({mon_e.is_err, !mon_e.is_err}));
        chk("ev_q", 64'({q5, q4, q3, q2, q1, q0}), 64'(mon_e.q));
        chk("ev_locked", 64'(locked), 64'(!mon_e.is_err));
        if (mon_e.is_err) chk("ev_code", 64'(err_code), 64'(mon_e.code));
      end
    end
  end

  initial begin
    // 1. Reset with a random bus, then acquisition with din = 0x11 + k.
    sel_n = 6'($urandom);
    din   = W'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", 64'({q5, q4, q3, q2, q1, q0}), 64'(0));
    chk("rst_flags", 64'({frame_done, err, err_code, locked}), 64'(0));
    sel_n = 6'($urandom);
    din   = W'($urandom);
    @(posedge clk);
    #1;
    chk("rst_q_2", 64'({q5, q4, q3, q2, q1, q0}), 64'(0));
    rst = 1'b0;
    put(6'h3f, '0, 2, -1, EV_NONE, 2'b00);
    put(sl(5), 6'h16, 1, 5, EV_NONE, 2'b00);
    chk("lock_not_yet", 64'(locked), 64'(0));
    put(sl(4), 6'h15, 1, 4, EV_NONE, 2'b00);
    chk("lock_two_edges", 64'(locked), 64'(1));
    chk("acq_q5", 64'(q5), 64'(6'h16));
    scan_from(3, 6'h11, 1);

    // 2. Ten back-to-back frames with 1..3 cycle holds.
    for (int f = 0; f < 10; f++) scan_from(5, 8'h20 + 3 * f, 3);

    // 3. Order error: 5, 4, then 2.
    put(sl(5), 6'h25, 1, 5, EV_NONE, 2'b00);
    put(sl(4), 6'h24, 1, 4, EV_NONE, 2'b00);
    put(sl(2), 6'h3e, 1, -1, EV_ERR, 2'b10);
    @(posedge clk);
    #1;
    chk("order_err", 64'({err, err_code}), 64'(3'b110));
    chk("order_unlock", 64'(locked), 64'(0));
    put(sl(3), 6'h01, 1, -1, EV_NONE, 2'b00);
    scan_from(5, 6'h30, 1);

    // 4. Illegal select in LOCK, ignored in HUNT; BLANK in LOCK is harmless.
    put(sl(5), 6'h0a, 1, 5, EV_NONE, 2'b00);
    put(6'b001111, 6'h3f, 1, -1, EV_ERR, 2'b01);
    put(6'b000000, 6'h15, 2, -1, EV_NONE, 2'b00);
    put(sl(5), 6'h0b, 1, 5, EV_NONE, 2'b00);
    put(sl(4), 6'h0c, 1, 4, EV_NONE, 2'b00);
    put(6'h3f, 6'h2a, 5, -1, EV_NONE, 2'b00);
    scan_from(3, 6'h08, 1);

    // 5. Timeout: advance to 3 then 8 held cycles errors; 7 held cycles does not.
    put(sl(5), 6'h1d, 1, 5, EV_NONE, 2'b00);
    put(sl(4), 6'h1c, 1, 4, EV_NONE, 2'b00);
    put(sl(3), 6'h1b, 9, 3, EV_ERR, 2'b11);
    chk("tout_early", 64'(err), 64'(0));
    put(sl(2), 6'h1a, 1, -1, EV_NONE, 2'b00);
    chk("tout_exact", 64'({err, err_code}), 64'(3'b111));
    chk("tout_unlock", 64'(locked), 64'(0));
    put(sl(5), 6'h2d, 1, 5, EV_NONE, 2'b00);
    put(sl(4), 6'h2c, 1, 4, EV_NONE, 2'b00);
    put(sl(3), 6'h2b, 8, 3, EV_NONE, 2'b00);
    scan_from(2, 6'h27, 1);

    // 6. Enable low mid-frame for 20 cycles while the bus churns.
    put(sl(5), 6'h35, 1, 5, EV_NONE, 2'b00);
    put(sl(4), 6'h34, 1, 4, EV_NONE, 2'b00);
    put(sl(3), 6'h33, 2, 3, EV_NONE, 2'b00);
    en = 1'b0;
    for (int i = 0; i < 19; i++) put(6'($urandom), W'($urandom), 1, -1, EV_NONE, 2'b00);
    put(6'b010101, 6'h3c, 1, -1, EV_NONE, 2'b00);
    for (int k = 0; k < 6; k++)
      chk("en_hold_q", 64'({q5, q4, q3, q2, q1, q0} >> (W * k)) & 64'(6'h3f), 64'(exp_q[k]));
    chk("en_hold_locked", 64'(locked), 64'(1));
    en = 1'b1;
    put(sl(2), 6'h32, 1, 2, EV_NONE, 2'b00);
    scan_from(1, 6'h30, 1);

    // Asynchronous reset between edges clears q at once.
    put(sl(5), 6'h15, 1, 5, EV_NONE, 2'b00);
    put(sl(4), 6'h14, 1, 4, EV_NONE, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q", 64'({q5, q4, q3, q2, q1, q0}), 64'(0));
    chk("arst_flags", 64'({locked, err, frame_done}), 64'(0));
    exp_q = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    put(6'h3f, 6'h00, 1, -1, EV_NONE, 2'b00);
    scan_from(5, 6'h05, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_capture.md
# scan_capture

Receiver for the six-digit multiplexed display scan bus. It samples the active-low digit-select lines and the shared data lines, checks the scan order, and rebuilds the six per-digit data words into parallel registers. It sits at the far end of the scan bus and is used for loop-back checking of the display driver and for feeding a remote display model. It flags illegal selects, out-of-order scans and stalled scans.

## Interface

Parameters:
- W, 6, width of each digit data word.
- TIMEOUT, 1024, consecutive enabled cycles without a new select before a stall error (minimum 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable. When low, inputs are ignored and all state is held.
- sel_n  input  6  active-low digit select. Bit k low selects digit k. The bus scans k = 5, 4, 3, 2, 1, 0, 5, …
- din  input  W  data for the currently selected digit.
- q0 … q5  output  W each  captured data for digits 0 to 5.
- frame_done  output  1  one-cycle pulse when a complete, in-order frame (5 down to 0) has been captured.
- locked  output  1  high while the FSM is in LOCK.
- err  output  1  one-cycle pulse on any detected error.
- err_code  output  2  cause of the last error: 01 illegal select, 10 order, 11 timeout. Held until the next error.

## Operation

- **Input stage.** sel_n and din are registered (s_sel, s_din) on every enabled edge. All decoding uses these registered values.
- **Decode of s_sel:**
  - Exactly one bit low gives a valid index k.
  - All ones is BLANK: no write, no error.
  - Any other pattern is ILLEGAL.
- **FSM states: HUNT, LOCK.**
- **HUNT:**
  - Index 5 writes q5 and moves to LOCK with expect = 4, prev = 5.
  - Any other valid index, BLANK or ILLEGAL: no write, no error; stay in HUNT.
- **LOCK:**
  - Index == prev: rewrite q[k]. This is a held select and is legal.
  - Index == expect: write q[k], set prev = k, set expect = k − 1. From index 0, wrap expect to 5.
  - Capturing index 0 via the expect path raises frame_done.
  - Wrap from 0 to 5 is the normal expect path. A new frame simply continues.
  - Any other valid index: err with code 10, no write, go to HUNT.
  - ILLEGAL: err with code 01, no write, go to HUNT.
  - BLANK: no write, no error.
- **Stall counter:**
  - Counts enabled cycles in LOCK since the last expect-path advance. Held selects and BLANK do not reset it.
  - Reaching TIMEOUT raises err with code 11 and moves to HUNT. The counter is cleared on that transition.
- **Error handling:**
  - q registers keep their last values on error.
  - Returning to HUNT drops locked.
  - If an error and a frame_done condition coincide, the error wins and frame_done stays low.
- **en low:** input registers, FSM, counter and outputs all hold. frame_done and err are forced low.

## Timing

- **Reset values:**
  - q0 … q5 = 0
  - frame_done = 0, err = 0, err_code = 00, locked = 0
  - FSM in HUNT, counter = 0
  - s_sel = all ones, s_din = 0
- **Latency:** sel_n/din sampled at edge N update q[k] at edge N+1, so they are visible two edges after being presented.
- **frame_done** is asserted at the same edge at which q0 updates. It is high for exactly one cycle.
- **err** is one cycle wide. err_code updates at the same edge and locked falls at the same edge.
- **Throughput:** one select change per clock is supported, which is the driver's full rate. A frame is 6 cycles, so frame_done can repeat every 6 cycles.
- **Reset mid-frame:** asynchronous clear; the bus is reacquired at the next index 5.

## Test plan

1. **Reset and acquisition.**
   - Stimulus: assert rst with a random bus, then release; drive the scan 5…0 with din = 0x11 + k.
   - Required response: all outputs 0 during reset; locked rises 2 edges after the first index-5 select; q5…q0 = 0x16…0x11; frame_done pulses once, together with the q0 update.
2. **Continuous scan with held selects.**
   - Stimulus: 10 back-to-back frames where each select is held for 1–3 random cycles.
   - Required response: frame_done every frame, no err, q matches the last din per digit.
3. **Order error.**
   - Stimulus: scan 5, 4, then index 2.
   - Required response: err pulse with err_code = 10; locked drops; q2 unchanged; reacquisition at the next index 5.
4. **Illegal select vs. BLANK.**
   - Stimulus: in LOCK, drive sel_n = 6'b001111; after reacquiring, drive 6'b111111 for 5 cycles.
   - Required response: the first gives err with code 01. The blank causes no err and no write, and the scan then resumes cleanly.
5. **Timeout.**
   - Stimulus: with TIMEOUT = 8, hold index 3 for 8 cycles in LOCK.
   - Required response: err with code 11 exactly at the eighth count; locked = 0. With only 7 cycles of hold: no error.
6. **Enable and asynchronous reset mid-frame.**
   - Stimulus: drop en for 20 cycles mid-frame while changing the bus.
   - Required response: no state change and no timeout. Asserting rst mid-frame clears all q immediately, without waiting for a clock edge.
